// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types: EX control bundle, its NOP value and datapath width defaults
// used by the decoder, the ID/EX register and the forwarding unit.
package rv_pipe_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic       alusrc;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] aluop;
    logic [2:0] immset;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'(10'd0);

  // An invalid slot must never carry live control into EX.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
    gate_ctrl = valid ? c : CTRL_NOP;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds a source that the
// instruction in ID actually reads. x0 never counts as a dependency.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              e_valid,
  input  logic              e_mem_read,
  input  logic [REG_AW-1:0] e_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  output logic              load_use
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1 = id_use_rs1 & (e_rd == id_rs1);
  assign w_hit_rs2 = id_use_rs2 & (e_rd == id_rs2);
  assign load_use  = e_valid & e_mem_read & (e_rd != {REG_AW{1'b0}}) & id_valid
                   & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with load-use bubble insertion and stall_D back-pressure.
// Optional event counters are built only when ID_EX_PERF_EN is defined.
module id_ex_stage_reg #(
  parameter int XLEN   = rv_pipe_pkg::XLEN,
  parameter int REG_AW = rv_pipe_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rdata1,
  input  logic [XLEN-1:0]   id_rdata2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [2:0]        id_immset,
  input  logic [3:0]        id_aluop,
  input  logic              id_alusrc,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush_E,
  input  logic              hold_E,
  output logic              validE,
  output logic [XLEN-1:0]   pcE,
  output logic [REG_AW-1:0] rs1_out,
  output logic [REG_AW-1:0] rs2_out,
  output logic [REG_AW-1:0] rd_outE,
  output logic [XLEN-1:0]   rdata1E,
  output logic [XLEN-1:0]   rdata2E,
  output logic [XLEN-1:0]   immE,
  output logic [2:0]        immsetE,
  output logic [3:0]        aluopE,
  output logic              ALUsrcE,
  output logic              reg_writeE,
  output logic              mem_readE,
  output logic              mem_writeE,
  output logic              stall_D,
  output logic [CNT_W-1:0]  perf_bubbles,
  output logic [CNT_W-1:0]  perf_flushes
);
  import rv_pipe_pkg::*;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_rdata1;
  logic [XLEN-1:0]   r_rdata2;
  logic [XLEN-1:0]   r_imm;
  ctrl_t             r_ctrl;

  logic  w_load_use;
  ctrl_t w_id_ctrl;

  load_use_detect #(.REG_AW(REG_AW)) u_lud (
    .e_valid    (r_valid),
    .e_mem_read (r_ctrl.mem_read),
    .e_rd       (r_rd),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .load_use   (w_load_use)
  );

  assign w_id_ctrl = gate_ctrl({id_alusrc, id_reg_write, id_mem_read, id_mem_write,
                                id_aluop, id_immset}, id_valid);

  // A flush overrides any stall request; nothing is stalled while in reset.
  assign stall_D = rst_n & ~flush_E & (hold_E | w_load_use);

  // Stage register: reset, flush bubble, hold, load-use bubble, else load from ID.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_E || (!hold_E && w_load_use)) begin
      r_valid  <= 1'b0;
      r_pc     <= {XLEN{1'b0}};
      r_rs1    <= {REG_AW{1'b0}};
      r_rs2    <= {REG_AW{1'b0}};
      r_rd     <= {REG_AW{1'b0}};
      r_rdata1 <= {XLEN{1'b0}};
      r_rdata2 <= {XLEN{1'b0}};
      r_imm    <= {XLEN{1'b0}};
      r_ctrl   <= CTRL_NOP;
    end else if (!hold_E) begin
      r_valid  <= id_valid;
      r_pc     <= id_pc;
      r_rs1    <= id_rs1;
      r_rs2    <= id_rs2;
      r_rd     <= id_rd;
      r_rdata1 <= id_rdata1;
      r_rdata2 <= id_rdata2;
      r_imm    <= id_imm;
      r_ctrl   <= w_id_ctrl;
    end
  end

  assign validE     = r_valid;
  assign pcE        = r_pc;
  assign rs1_out    = r_rs1;
  assign rs2_out    = r_rs2;
  assign rd_outE    = r_rd;
  assign rdata1E    = r_rdata1;
  assign rdata2E    = r_rdata2;
  assign immE       = r_imm;
  assign immsetE    = r_ctrl.immset;
  assign aluopE     = r_ctrl.aluop;
  assign ALUsrcE    = r_ctrl.alusrc;
  assign reg_writeE = r_ctrl.reg_write;
  assign mem_readE  = r_ctrl.mem_read;
  assign mem_writeE = r_ctrl.mem_write;

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] r_bubbles;
  logic [CNT_W-1:0] r_flushes;

  // Saturating event counters for flush and load-use bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubbles <= {CNT_W{1'b0}};
      r_flushes <= {CNT_W{1'b0}};
    end else if (flush_E) begin
      if (r_flushes != {CNT_W{1'b1}}) r_flushes <= r_flushes + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!hold_E && w_load_use) begin
      if (r_bubbles != {CNT_W{1'b1}}) r_bubbles <= r_bubbles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign perf_bubbles = r_bubbles;
  assign perf_flushes = r_flushes;
`else
  assign perf_bubbles = {CNT_W{1'b0}};
  assign perf_flushes = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: behavioural EX-slot model checked every cycle
// plus directed literal checks (reset, load-use, x0, flush vs stall, hold, random ALU stream).
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [63:0] id_pc = 64'd0;
  logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [63:0] id_rdata1 = 64'd0, id_rdata2 = 64'd0, id_imm = 64'd0;
  logic [2:0]  id_immset = 3'd0;
  logic [3:0]  id_aluop = 4'd0;
  logic        id_alusrc = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
  logic        flush_E = 1'b0, hold_E = 1'b0;

  logic        validE;
  logic [63:0] pcE, rdata1E, rdata2E, immE;
  logic [4:0]  rs1_out, rs2_out, rd_outE;
  logic [2:0]  immsetE;
  logic [3:0]  aluopE;
  logic        ALUsrcE, reg_writeE, mem_readE, mem_writeE, stall_D;
  logic [31:0] perf_bubbles, perf_flushes;

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_immset(id_immset), .id_aluop(id_aluop), .id_alusrc(id_alusrc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush_E(flush_E), .hold_E(hold_E), .validE(validE), .pcE(pcE),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_outE(rd_outE), .rdata1E(rdata1E),
    .rdata2E(rdata2E), .immE(immE), .immsetE(immsetE), .aluopE(aluopE),
    .ALUsrcE(ALUsrcE), .reg_writeE(reg_writeE), .mem_readE(mem_readE),
    .mem_writeE(mem_writeE), .stall_D(stall_D),
    .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [63:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] d1, d2, imm;
    logic [2:0]  immset;
    logic [3:0]  aluop;
    logic        alusrc, rw, mr, mw;
  } eslot_t;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  eslot_t m_e = '0;
  logic [31:0] m_bub = 32'd0, m_fl = 32'd0;
  eslot_t dut_e;

  assign dut_e = '{validE, pcE, rs1_out, rs2_out, rd_outE, rdata1E, rdata2E, immE,
                   immsetE, aluopE, ALUsrcE, reg_writeE, mem_readE, mem_writeE};

  // Model: does the instruction in ID read the register a load in EX is producing?
  function automatic logic model_dep(input eslot_t e);
    logic dep;
    dep = 1'b0;
    if (e.v && e.mr && e.rd != 5'd0 && id_valid) begin
      if (id_use_rs1 && id_rs1 == e.rd) dep = 1'b1;
      if (id_use_rs2 && id_rs2 == e.rd) dep = 1'b1;
    end
    return dep;
  endfunction

  function automatic logic model_stall(input eslot_t e);
    return rst_n && !flush_E && (hold_E || model_dep(e));
  endfunction

  function automatic eslot_t model_next(input eslot_t e);
    eslot_t n;
    if (!rst_n || flush_E) n = '0;
    else if (hold_E) n = e;
    else if (model_dep(e)) n = '0;
    else begin
      n = '{id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2, id_imm,
            id_immset, id_aluop, id_alusrc, id_reg_write, id_mem_read, id_mem_write};
      if (!id_valid) {n.immset, n.aluop, n.alusrc, n.rw, n.mr, n.mw} = 10'd0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m_e <= model_next(m_e);
    if (!rst_n) begin
      m_bub <= 32'd0;
      m_fl  <= 32'd0;
    end else if (flush_E) m_fl <= m_fl + 32'd1;
    else if (!hold_E && model_dep(m_e)) m_bub <= m_bub + 32'd1;
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dut_e !== m_e) begin
        errors++;
        $display("FAIL eslot t=%0t actual=%h required=%h", $time, dut_e, m_e);
      end
      checks++;
      if (stall_D !== model_stall(m_e)) begin
        errors++;
        $display("FAIL stall_D t=%0t actual=%b required=%b", $time, stall_D, model_stall(m_e));
      end
      checks++;
`ifdef ID_EX_PERF_EN
      if (perf_bubbles !== m_bub || perf_flushes !== m_fl) begin
        errors++;
        $display("FAIL perf t=%0t actual=%0d/%0d required=%0d/%0d", $time,
                 perf_bubbles, perf_flushes, m_bub, m_fl);
      end
`else
      if (perf_bubbles !== 32'd0 || perf_flushes !== 32'd0) begin
        errors++;
        $display("FAIL perf_tied t=%0t actual=%0d/%0d required=0/0", $time,
                 perf_bubbles, perf_flushes);
      end
`endif
    end
  end

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic rw, input logic mr, input logic mw, input logic asrc);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_alusrc = asrc;
    id_pc = id_pc + 64'd4;
    id_rdata1 = {$urandom, $urandom}; id_rdata2 = {$urandom, $urandom};
    id_imm = {$urandom, $urandom};
    id_aluop = 4'($urandom_range(15, 0)); id_immset = 3'($urandom_range(7, 0));
  endtask

  task automatic ins_ld(input logic [4:0] rd, input logic [4:0] rs1);
    set_ins(1'b1, rd, rs1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic ins_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    set_ins(1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ins_sd(input logic [4:0] rs1, input logic [4:0] rs2);
    set_ins(1'b1, 5'd0, rs1, rs2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    logic [63:0] pc_a;
    // T1: reset with valid ID traffic and hold_E asserted.
    rst_n = 1'b0; hold_E = 1'b1;
    ins_alu(5'd3, 5'd1, 5'd2);
    step(); chk_en = 1'b1;
    lit("t1_validE", {63'd0, validE}, 64'd0);
    lit("t1_stall", {63'd0, stall_D}, 64'd0);
    step();
    lit("t1_pcE", pcE, 64'd0);
    rst_n = 1'b1; hold_E = 1'b0;
    step();
    lit("t1_load_pc", pcE, 64'd4);
    lit("t1_load_rd", {59'd0, rd_outE}, 64'd3);

    // T2: ld x5 then add x6,x5,x7 -> one bubble.
    ins_ld(5'd5, 5'd1); step();
    ins_alu(5'd6, 5'd5, 5'd7); #1;
    lit("t2_stall", {63'd0, stall_D}, 64'd1);
    step();
    lit("t2_bubble_v", {63'd0, validE}, 64'd0);
    lit("t2_bubble_rw", {63'd0, reg_writeE}, 64'd0);
    lit("t2_stall_rel", {63'd0, stall_D}, 64'd0);
    step();
    lit("t2_add_rs1", {59'd0, rs1_out}, 64'd5);
    lit("t2_add_v", {63'd0, validE}, 64'd1);
`ifdef ID_EX_PERF_EN
    lit("t2_perf_bub", {32'd0, perf_bubbles}, 64'd1);
`endif

    // T3: ld x0 never stalls; store data dependency and same reg on both sources.
    ins_ld(5'd0, 5'd1); step();
    ins_alu(5'd6, 5'd0, 5'd0); #1;
    lit("t3_x0_stall", {63'd0, stall_D}, 64'd0);
    step();
    lit("t3_x0_valid", {63'd0, validE}, 64'd1);
    ins_ld(5'd5, 5'd2); step();
    ins_sd(5'd3, 5'd5); id_use_rs1 = 1'b1; #1;
    lit("t3_sd_stall", {63'd0, stall_D}, 64'd1);
    step(); step();
    lit("t3_sd_in_E", {63'd0, mem_writeE}, 64'd1);
    ins_ld(5'd9, 5'd2); step();
    ins_alu(5'd10, 5'd9, 5'd9); #1;
    lit("t3_same_stall", {63'd0, stall_D}, 64'd1);
    step();
    lit("t3_same_once", {63'd0, stall_D}, 64'd0);
    step();

    // T4: flush coincident with load-use.
    ins_ld(5'd5, 5'd1); step();
    ins_alu(5'd6, 5'd5, 5'd7); flush_E = 1'b1; #1;
    lit("t4_stall", {63'd0, stall_D}, 64'd0);
    step(); flush_E = 1'b0;
    lit("t4_bubble", {60'd0, validE, reg_writeE, mem_readE, mem_writeE}, 64'd0);
`ifdef ID_EX_PERF_EN
    lit("t4_perf_fl", {32'd0, perf_flushes}, 64'd1);
    lit("t4_perf_bub", {32'd0, perf_bubbles}, 64'd3);
`endif

    // T5: hold three cycles while ID changes.
    ins_alu(5'd11, 5'd1, 5'd2); pc_a = id_pc; step();
    hold_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins_alu(5'(12 + i), 5'd3, 5'd4); #1;
      lit("t5_stall", {63'd0, stall_D}, 64'd1);
      step();
      lit("t5_frozen", pcE, pc_a);
    end
    hold_E = 1'b0; step();
    lit("t5_release", pcE, pc_a + 64'd12);

    // T6: random independent ALU stream, occasional invalid slots.
    for (int i = 0; i < 100; i++) begin
      set_ins(($urandom_range(7, 0) != 0), 5'($urandom_range(31, 1)), 5'($urandom),
              5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom),
              1'($urandom));
      step();
    end
    id_valid = 1'b0;
    step(); step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
